// File: rtl/ne_win_ctrl.sv
// Window sequencer for the nonlinear-energy unit: drops two warm-up terms, sums WIN_LEN-2 terms per window.
// Define NE_WIN_THRESH_EN to add the thresh input and registered m_detect flag.
module ne_win_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NE_WIDTH   = 64,
  parameter int WIN_LEN    = 256,
  localparam int ACC_WIDTH = NE_WIDTH + $clog2(WIN_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic signed [DATA_WIDTH-1:0] ne_din,
  output logic                         ne_en,
  output logic                         ne_rst,
  input  logic signed [NE_WIDTH-1:0]   ne_dout,
`ifdef NE_WIN_THRESH_EN
  input  logic signed [ACC_WIDTH-1:0]  thresh,
  output logic                         m_detect,
`endif
  output logic signed [ACC_WIDTH-1:0]  m_sum,
  output logic [15:0]                  m_win,
  output logic                         m_valid,
  input  logic                         m_ready
);

  localparam int CNT_W = $clog2(WIN_LEN);
  localparam int EXT_W = ACC_WIDTH - NE_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  typedef enum logic [1:0] {CLEAR, FILL, DRAIN, HOLD} state_t;

  state_t                      state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        pend_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] m_sum_q;
  logic [15:0]                 m_win_q;
  logic                        s_ready_q;
  logic                        ne_rst_q;
  logic                        m_valid_q;
  logic                        accept;
  logic signed [ACC_WIDTH-1:0] term_d;
  logic signed [ACC_WIDTH-1:0] sum_d;
`ifdef NE_WIN_THRESH_EN
  logic                        m_detect_q;
`endif

  assign accept = s_valid & s_ready_q;
  assign term_d = {{EXT_W{ne_dout[NE_WIDTH-1]}}, ne_dout};
  assign sum_d  = acc_q + term_d;

  assign s_ready = s_ready_q;
  assign ne_din  = s_data;
  assign ne_en   = ~accept;
  assign ne_rst  = ne_rst_q;
  assign m_sum   = m_sum_q;
  assign m_win   = m_win_q;
  assign m_valid = m_valid_q;
`ifdef NE_WIN_THRESH_EN
  assign m_detect = m_detect_q;
`endif

  // Flag outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      acc_q      <= '0;
      m_sum_q    <= '0;
      m_win_q    <= '0;
      s_ready_q  <= 1'b0;
      ne_rst_q   <= 1'b1;
      m_valid_q  <= 1'b0;
`ifdef NE_WIN_THRESH_EN
      m_detect_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        CLEAR: begin
          acc_q     <= '0;
          cnt_q     <= '0;
          pend_q    <= 1'b0;
          ne_rst_q  <= 1'b0;
          s_ready_q <= 1'b1;
          state_q   <= FILL;
        end
        FILL: begin
          // The term of the previous accept is on ne_dout for exactly this cycle.
          if (pend_q) acc_q <= sum_d;
          pend_q <= accept && (cnt_q >= CNT_TWO);
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              s_ready_q <= 1'b0;
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          m_sum_q    <= sum_d;
`ifdef NE_WIN_THRESH_EN
          m_detect_q <= sum_d > thresh;
`endif
          pend_q     <= 1'b0;
          m_valid_q  <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_win_q   <= m_win_q + 16'd1;
            ne_rst_q  <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        default: begin
          ne_rst_q  <= 1'b1;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          state_q   <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ne_win_ctrl.sv
// Testbench for ne_win_ctrl with a behavioural NE unit and a closed-form window-sum reference.
module tb_ne_win_ctrl;
  localparam int DW  = 16;
  localparam int NW  = 34;
  localparam int WIN = 4;
  localparam int AW  = NW + $clog2(WIN);

  typedef longint win_t [WIN];

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] s_data = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] ne_din;
  logic                 ne_en;
  logic                 ne_rst;
  logic signed [NW-1:0] ne_dout = '0;
  logic signed [AW-1:0] m_sum;
  logic [15:0]          m_win;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
`ifdef NE_WIN_THRESH_EN
  logic signed [AW-1:0] thresh = '0;
  logic                 m_detect;
`endif

  int          tests = 0;
  int          fails = 0;
  int          en_cnt = 0;
  int          nerst_cnt = 0;
  logic [15:0] win_exp = '0;
  longint      ne_x1 = 0;
  longint      ne_x2 = 0;

  ne_win_ctrl #(.DATA_WIDTH(DW), .NE_WIDTH(NW), .WIN_LEN(WIN)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ne_din(ne_din), .ne_en(ne_en), .ne_rst(ne_rst), .ne_dout(ne_dout),
`ifdef NE_WIN_THRESH_EN
    .thresh(thresh), .m_detect(m_detect),
`endif
    .m_sum(m_sum), .m_win(m_win), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // NE unit: registered x[k-1]^2 - x[k]*x[k-2], advances only while en is low.
  always @(posedge clk) begin
    if (ne_rst === 1'b1) begin
      ne_x1   <= 0;
      ne_x2   <= 0;
      ne_dout <= '0;
    end else if (ne_en === 1'b0) begin
      ne_dout <= NW'(ne_x1 * ne_x1 - longint'(ne_din) * ne_x2);
      ne_x2   <= ne_x1;
      ne_x1   <= longint'(ne_din);
    end
  end

  always @(posedge clk) begin
    if (ne_en === 1'b0) en_cnt <= en_cnt + 1;
    if (ne_rst === 1'b1) nerst_cnt <= nerst_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint ref_sum(input win_t xs);
    longint s = 0;
    for (int k = 2; k < WIN; k++) s += xs[k-1] * xs[k-1] - xs[k] * xs[k-2];
    return s;
  endfunction

  task automatic push(input longint v, input int gap, output bit to);
    int t = 0;
    to = 1'b0;
    s_data  = DW'(v);
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) to = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive_window(input win_t xs, input int gap, input int hold,
                              output logic signed [AW-1:0] sum_o, output logic [15:0] win_o,
                              output bit timing_ok, output bit stable_ok, output logic det_o);
    bit to;
    bit any_to = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      push(xs[i], (i == WIN - 1) ? 0 : gap, to);
      any_to |= to;
    end
    timing_ok = !any_to && (m_valid === 1'b0) && (s_ready === 1'b0);
    @(negedge clk);
    if (m_valid !== 1'b1) timing_ok = 1'b0;
    sum_o = m_sum;
    win_o = m_win;
`ifdef NE_WIN_THRESH_EN
    det_o = m_detect;
`else
    det_o = 1'b0;
`endif
    stable_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_sum !== sum_o || m_win !== win_o || s_ready !== 1'b0)
        stable_ok = 1'b0;
    end
  endtask

  task automatic release_window();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    win_exp = win_exp + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    tests++; if (ne_en !== 1'b1) begin fails++; $display("FAIL reset_ne_en: got %b want 1", ne_en); end
    tests++; if (ne_rst !== 1'b1) begin fails++; $display("FAIL reset_ne_rst: got %b want 1", ne_rst); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    tests++; if (m_sum !== '0) begin fails++; $display("FAIL reset_m_sum: got %0d want 0", m_sum); end
    tests++; if (m_win !== 16'd0) begin fails++; $display("FAIL reset_m_win: got %0d want 0", m_win); end
`ifdef NE_WIN_THRESH_EN
    tests++; if (m_detect !== 1'b0) begin fails++; $display("FAIL reset_m_detect: got %b want 0", m_detect); end
`endif
    rst = 1'b1;
    win_exp = '0;
    @(negedge clk);
    tests++; if (s_ready !== 1'b1 || ne_rst !== 1'b0) begin
      fails++; $display("FAIL reset_to_fill: s_ready=%b ne_rst=%b want 1/0", s_ready, ne_rst);
    end
  endtask

  task automatic test_basic();
    win_t xs = '{1, 2, 3, 4};
    logic signed [AW-1:0] s; logic [15:0] w; bit tok, sok; logic d;
    drive_window(xs, 0, 0, s, w, tok, sok, d);
    $display("[TB] basic window: sum=%0d win=%0d", s, w);
    tests++; if (!tok) begin fails++; $display("FAIL basic_timing: m_valid/s_ready sequence wrong, got m_valid=%b", m_valid); end
    tests++; if (s !== AW'(2)) begin fails++; $display("FAIL basic_sum: got %0d want 2", s); end
    tests++; if (w !== win_exp) begin fails++; $display("FAIL basic_win: got %0d want %0d", w, win_exp); end
  endtask

  task automatic test_constant();
    win_t xs = '{3, 3, 3, 3};
    logic signed [AW-1:0] s; logic [15:0] w; bit tok, sok; logic d;
    int n0 = nerst_cnt;
    release_window();
    drive_window(xs, 0, 0, s, w, tok, sok, d);
    $display("[TB] constant window: sum=%0d win=%0d", s, w);
    tests++; if (nerst_cnt - n0 != 1) begin fails++; $display("FAIL const_ne_rst_pulse: got %0d cycles want 1", nerst_cnt - n0); end
    tests++; if (s !== AW'(0)) begin fails++; $display("FAIL const_sum: got %0d want 0", s); end
    tests++; if (w !== win_exp) begin fails++; $display("FAIL const_win: got %0d want %0d", w, win_exp); end
    release_window();
  endtask

  task automatic test_signed();
    win_t xs = '{0, -5, 0, 0};
    logic signed [AW-1:0] s; logic [15:0] w; bit tok, sok; logic d;
    drive_window(xs, 0, 0, s, w, tok, sok, d);
    $display("[TB] signed window: sum=%0d win=%0d", s, w);
    tests++; if (s !== AW'(25)) begin fails++; $display("FAIL signed_sum: got %0d want 25", s); end
    release_window();
  endtask

  task automatic test_bubbles();
    win_t xs = '{1, 2, 3, 4};
    logic signed [AW-1:0] s; logic [15:0] w; bit tok, sok; logic d;
    int e0 = en_cnt;
    drive_window(xs, 3, 0, s, w, tok, sok, d);
    $display("[TB] bubble window: sum=%0d en_low=%0d", s, en_cnt - e0);
    tests++; if (en_cnt - e0 != 4) begin fails++; $display("FAIL bubble_ne_en: got %0d low cycles want 4", en_cnt - e0); end
    tests++; if (s !== AW'(2)) begin fails++; $display("FAIL bubble_sum: got %0d want 2", s); end
    release_window();
  endtask

  task automatic test_backpressure();
    win_t xs = '{1, 2, 3, 4};
    logic signed [AW-1:0] s; logic [15:0] w; bit tok, sok; logic d;
    drive_window(xs, 0, 10, s, w, tok, sok, d);
    $display("[TB] backpressure window: sum=%0d win=%0d", s, w);
    tests++; if (!sok) begin fails++; $display("FAIL bp_stable: outputs moved during hold, now m_valid=%b m_sum=%0d", m_valid, m_sum); end
    tests++; if (s !== AW'(2) || w !== win_exp) begin fails++; $display("FAIL bp_result: got sum=%0d win=%0d want 2/%0d", s, w, win_exp); end
    release_window();
  endtask

  task automatic test_reset_mid();
    win_t xs = '{1, 2, 3, 4};
    logic signed [AW-1:0] s; logic [15:0] w; bit tok, sok; logic d; bit to;
    push(7, 0, to);
    push(-9, 0, to);
    rst = 1'b0;
    #1;
    tests++; if (s_ready !== 1'b0 || ne_en !== 1'b1 || ne_rst !== 1'b1 || m_valid !== 1'b0 ||
                 m_sum !== '0 || m_win !== 16'd0) begin
      fails++;
      $display("FAIL midreset_outputs: s_ready=%b ne_en=%b ne_rst=%b m_valid=%b m_sum=%0d m_win=%0d",
               s_ready, ne_en, ne_rst, m_valid, m_sum, m_win);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    win_exp = '0;
    drive_window(xs, 0, 0, s, w, tok, sok, d);
    $display("[TB] post-reset window: sum=%0d win=%0d", s, w);
    tests++; if (s !== AW'(2) || w !== 16'd0) begin fails++; $display("FAIL midreset_sum: got sum=%0d win=%0d want 2/0", s, w); end
    release_window();
  endtask

`ifdef NE_WIN_THRESH_EN
  task automatic test_thresh();
    win_t xa = '{1, 2, 3, 4};
    win_t xb = '{3, 3, 3, 3};
    logic signed [AW-1:0] s; logic [15:0] w; bit tok, sok; logic d;
    thresh = AW'(1);
    drive_window(xa, 0, 0, s, w, tok, sok, d);
    tests++; if (d !== 1'b1) begin fails++; $display("FAIL thresh_hi: got %b want 1", d); end
    release_window();
    drive_window(xb, 0, 0, s, w, tok, sok, d);
    tests++; if (d !== 1'b0) begin fails++; $display("FAIL thresh_lo: got %b want 0", d); end
    release_window();
  endtask
`endif

  task automatic test_random();
    win_t xs;
    logic signed [DW-1:0] r;
    logic signed [AW-1:0] s; logic [15:0] w; bit tok, sok; logic d;
    longint exp_sum;
    int gap, hold;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < WIN; i++) begin
        r = DW'($urandom);
        xs[i] = longint'(r);
      end
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      exp_sum = ref_sum(xs);
`ifdef NE_WIN_THRESH_EN
      thresh = AW'(exp_sum + longint'($urandom_range(0, 4)) - 2);
`endif
      drive_window(xs, gap, hold, s, w, tok, sok, d);
      $display("[TB] random window %0d: sum=%0d expected=%0d win=%0d", n, s, exp_sum, w);
      tests++; if (s !== AW'(exp_sum)) begin fails++; $display("FAIL rand_sum[%0d]: got %0d want %0d", n, s, exp_sum); end
      tests++; if (w !== win_exp) begin fails++; $display("FAIL rand_win[%0d]: got %0d want %0d", n, w, win_exp); end
      tests++; if (!tok || !sok) begin fails++; $display("FAIL rand_handshake[%0d]: timing=%b stable=%b want 1/1", n, tok, sok); end
`ifdef NE_WIN_THRESH_EN
      tests++; if (d !== (exp_sum > longint'(thresh))) begin
        fails++; $display("FAIL rand_detect[%0d]: got %b want %b", n, d, exp_sum > longint'(thresh));
      end
`endif
      release_window();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_constant();
    test_signed();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
`ifdef NE_WIN_THRESH_EN
    test_thresh();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
